// File: rtl/fir_pkg.sv
// Shared types and helpers for the N-tap FIR filter engine.
//   state_t    : controller states
//   acc_width  : full-precision accumulator width for a given configuration
//   saturate   : clip a wide signed value to a DATA_W-bit signed range
//   magnitude  : absolute value inside a DATA_W-bit signed range
package fir_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, MAC, DONE} state_t;

    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned num_taps);
        return data_w + coef_w + $clog2(num_taps);
    endfunction

    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned w);
        if (v > sat_max(w)) return sat_max(w);
        if (v < sat_min(w)) return sat_min(w);
        return v;
    endfunction

    // The most negative value has no positive counterpart; it maps to the maximum.
    function automatic logic signed [63:0] magnitude(input logic signed [63:0] v,
                                                     input int unsigned w);
        if (v == sat_min(w)) return sat_max(w);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Single-multiplier MAC and output stage.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the accumulator
//   enable   : accumulate sample*coef this cycle
//   sample   : signed sample operand (DATA_W)
//   coef     : signed coefficient operand (COEF_W)
//   result   : shaped output computed from acc + current product (DATA_W)
//   sat      : result was clipped (or the magnitude of the minimum value was taken)
// result/sat are combinational from the running sum so the caller can register
// them on the same edge that absorbs the last product.
module fir_mac
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned FRAC_BITS = 15,
    parameter int unsigned ACC_W     = 34,
    parameter int unsigned MAG_OUT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample,
    input  logic [COEF_W-1:0] coef,
    output logic [DATA_W-1:0] result,
    output logic              sat
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_shift;
    logic signed [63:0]       wide;
    logic signed [63:0]       clipped;
    logic signed [63:0]       shaped;

    always_comb begin
        product   = PROD_W'(signed'(sample)) * PROD_W'(signed'(coef));
        acc_sum   = acc + ACC_W'(product);
        acc_shift = acc_sum >>> FRAC_BITS;
        wide      = 64'(acc_shift);
        clipped   = saturate(wide, DATA_W);
        shaped    = (MAG_OUT != 0) ? magnitude(clipped, DATA_W) : clipped;
        result    = shaped[DATA_W-1:0];
        sat       = (clipped != wide) ||
                    ((MAG_OUT != 0) && (clipped == sat_min(DATA_W)));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/fir_filter_n.sv
// N-tap FIR filter engine, one tap per clock through a shared MAC.
//   clk, rst        : clock, synchronous active-high reset
//   sample_data     : signed sample, taken when data_ready=1 and not busy
//   fir_coefficient : signed coefficient, taken when load_coeff=1 and not busy
//   data_ready      : one-cycle new-sample pulse
//   load_coeff      : one-cycle coefficient-write pulse
//   modwait         : busy, requests are refused
//   fir_out         : last result (magnitude or signed), held
//   out_valid       : one-cycle pulse when fir_out updates
//   coeff_ready     : full coefficient set written since reset
//   block_done      : pulse on every BLOCK_LEN-th result
//   err             : saturation / overrun / dropped sample
module fir_filter_n
    import fir_pkg::*;
#(
    parameter int unsigned NUM_TAPS  = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned FRAC_BITS = 15,
    parameter int unsigned BLOCK_LEN = 1000,
    parameter int unsigned MAG_OUT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [COEF_W-1:0] fir_coefficient,
    input  logic              data_ready,
    input  logic              load_coeff,
    output logic              modwait,
    output logic [DATA_W-1:0] fir_out,
    output logic              out_valid,
    output logic              coeff_ready,
    output logic              block_done,
    output logic              err
);

    localparam int unsigned ACC_W = acc_width(DATA_W, COEF_W, NUM_TAPS);
    localparam int unsigned IDX_W = $clog2(NUM_TAPS);
    localparam int unsigned BLK_W = $clog2(BLOCK_LEN + 1);

    state_t            state;
    logic [DATA_W-1:0] x    [NUM_TAPS];
    logic [COEF_W-1:0] coef [NUM_TAPS];
    logic [DATA_W-1:0] sample_q;
    logic [IDX_W-1:0]  coef_idx;
    logic [IDX_W-1:0]  tap;
    logic [BLK_W-1:0]  block_cnt;
    logic [DATA_W-1:0] mac_result;
    logic              mac_sat;
    logic              last_tap;
    logic              overrun;

    assign last_tap = (tap == IDX_W'(NUM_TAPS - 1));
    assign overrun  = modwait && (data_ready || load_coeff);

    fir_mac #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W),
        .MAG_OUT   (MAG_OUT)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == SHIFT),
        .enable (state == MAC),
        .sample (x[tap]),
        .coef   (coef[tap]),
        .result (mac_result),
        .sat    (mac_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            modwait     <= 1'b0;
            fir_out     <= '0;
            out_valid   <= 1'b0;
            coeff_ready <= 1'b0;
            block_done  <= 1'b0;
            err         <= 1'b0;
            sample_q    <= '0;
            coef_idx    <= '0;
            tap         <= '0;
            block_cnt   <= '0;
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                x[k]    <= '0;
                coef[k] <= '0;
            end
        end else begin
            out_valid  <= 1'b0;
            block_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (load_coeff) begin
                        state   <= LOAD;
                        modwait <= 1'b1;
                        if (data_ready) err <= 1'b1;
                    end else if (data_ready) begin
                        state    <= SHIFT;
                        modwait  <= 1'b1;
                        sample_q <= sample_data;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    coef[coef_idx] <= fir_coefficient;
                    if (coef_idx == IDX_W'(NUM_TAPS - 1)) begin
                        coef_idx    <= '0;
                        coeff_ready <= 1'b1;
                    end else begin
                        coef_idx <= coef_idx + 1'b1;
                    end
                    state   <= IDLE;
                    modwait <= 1'b0;
                end
                SHIFT: begin
                    for (int unsigned k = 1; k < NUM_TAPS; k++) begin
                        x[k] <= x[k-1];
                    end
                    x[0]  <= sample_q;
                    tap   <= '0;
                    err   <= 1'b0;
                    state <= MAC;
                end
                MAC: begin
                    if (last_tap) begin
                        // Result is taken from acc + final product on this edge.
                        tap       <= '0;
                        state     <= DONE;
                        modwait   <= 1'b0;
                        fir_out   <= mac_result;
                        out_valid <= 1'b1;
                        if (mac_sat) err <= 1'b1;
                        if (block_cnt == BLK_W'(BLOCK_LEN - 1)) begin
                            block_cnt  <= '0;
                            block_done <= 1'b1;
                        end else begin
                            block_cnt <= block_cnt + 1'b1;
                        end
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Refused requests flag an error; this overrides the SHIFT clear.
            if (overrun) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_filter_n.sv
module tb_fir_filter_n;

    localparam int TAPS = 4;
    localparam int FRAC = 15;
    localparam int BLK  = 4;
    localparam int OP_RST  = 0;
    localparam int OP_LOAD = 1;
    localparam int OP_SAMP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_ready = 1'b0;
    logic        load_coeff = 1'b0;
    logic [15:0] sample_data = '0;
    logic [15:0] fir_coefficient = '0;

    logic        modwait, out_valid, coeff_ready, block_done, err;
    logic [15:0] fir_out;
    logic        modwait_s, out_valid_s, coeff_ready_s, block_done_s, err_s;
    logic [15:0] fir_out_s;

    always #5 clk = ~clk;

    fir_filter_n #(.NUM_TAPS(4), .DATA_W(16), .COEF_W(16), .FRAC_BITS(15),
                   .BLOCK_LEN(4), .MAG_OUT(1)) dut (
        .clk(clk), .rst(rst), .sample_data(sample_data),
        .fir_coefficient(fir_coefficient), .data_ready(data_ready),
        .load_coeff(load_coeff), .modwait(modwait), .fir_out(fir_out),
        .out_valid(out_valid), .coeff_ready(coeff_ready),
        .block_done(block_done), .err(err));

    fir_filter_n #(.NUM_TAPS(4), .DATA_W(16), .COEF_W(16), .FRAC_BITS(15),
                   .BLOCK_LEN(4), .MAG_OUT(0)) dut_sgn (
        .clk(clk), .rst(rst), .sample_data(sample_data),
        .fir_coefficient(fir_coefficient), .data_ready(data_ready),
        .load_coeff(load_coeff), .modwait(modwait_s), .fir_out(fir_out_s),
        .out_valid(out_valid_s), .coeff_ready(coeff_ready_s),
        .block_done(block_done_s), .err(err_s));

    int n_checks = 0;
    int n_fail   = 0;
    int bd_cnt   = 0;

    // Reference model: plain arithmetic over the sample history and coefficients.
    longint      x_m [TAPS];
    longint      c_m [TAPS];
    int          idx_m;
    bit          cr_m;
    bit          err_mag_m, err_sgn_m;
    int          res_m;
    logic [15:0] exp_mag_m, exp_sgn_m;

    typedef struct {
        int          op;
        logic [15:0] val;
        logic [15:0] e_mag;
        logic [15:0] e_sgn;
        bit          e_err_m;
        bit          e_err_s;
    } vec_t;
    vec_t vecs[$];

    function automatic void check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            x_m[i] = 0;
            c_m[i] = 0;
        end
        idx_m = 0; cr_m = 0; err_mag_m = 0; err_sgn_m = 0; res_m = 0;
    endfunction

    function automatic void model_load(logic [15:0] c);
        c_m[idx_m] = longint'(signed'(c));
        if (idx_m == TAPS - 1) begin
            idx_m = 0;
            cr_m  = 1;
        end else begin
            idx_m++;
        end
    endfunction

    function automatic void model_accept(logic [15:0] s);
        for (int i = TAPS - 1; i > 0; i--) x_m[i] = x_m[i-1];
        x_m[0] = longint'(signed'(s));
        err_mag_m = 0;
        err_sgn_m = 0;
    endfunction

    function automatic void model_finish();
        longint sum = 0;
        longint r;
        for (int i = 0; i < TAPS; i++) sum += x_m[i] * c_m[i];
        r = sum >>> FRAC;
        if (r > 32767) begin
            r = 32767; err_mag_m = 1; err_sgn_m = 1;
        end else if (r < -32768) begin
            r = -32768; err_mag_m = 1; err_sgn_m = 1;
        end
        exp_sgn_m = 16'(r);
        if (r == -32768) begin
            exp_mag_m = 16'h7FFF;
            err_mag_m = 1;
        end else begin
            exp_mag_m = 16'((r < 0) ? -r : r);
        end
        res_m++;
    endfunction

    task automatic do_reset();
        rst = 1'b1; data_ready = 1'b0; load_coeff = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_load(input logic [15:0] c);
        @(negedge clk);
        load_coeff = 1'b1; fir_coefficient = c;
        @(negedge clk);
        load_coeff = 1'b0;
        check("load_modwait", modwait, 1);
        model_load(c);
        @(negedge clk);
        check("coeff_ready", coeff_ready, cr_m);
        check("coeff_ready_sgn", coeff_ready_s, cr_m);
    endtask

    task automatic wait_result(input int cyc0, input bit use_tab, input logic [15:0] e_mag,
                               input logic [15:0] e_sgn, input bit e_err_m, input bit e_err_s);
        int cyc = cyc0;
        while (out_valid !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, TAPS + 2);
        model_finish();
        if (!use_tab) begin
            e_mag = exp_mag_m; e_sgn = exp_sgn_m; e_err_m = err_mag_m; e_err_s = err_sgn_m;
        end
        check("fir_out_mag", fir_out, e_mag);
        check("fir_out_sgn", fir_out_s, e_sgn);
        check("out_valid_sgn", out_valid_s, 1);
        check("err_mag", err, e_err_m);
        check("err_sgn", err_s, e_err_s);
        check("block_done", block_done, (res_m % BLK) == 0);
        check("block_done_sgn", block_done_s, (res_m % BLK) == 0);
        if (block_done) bd_cnt++;
        @(negedge clk);
        check("out_valid_pulse", out_valid, 0);
    endtask

    task automatic do_sample(input logic [15:0] s, input bit use_tab, input logic [15:0] e_mag,
                             input logic [15:0] e_sgn, input bit e_err_m, input bit e_err_s);
        @(negedge clk);
        data_ready = 1'b1; sample_data = s;
        @(negedge clk);
        data_ready = 1'b0;
        check("busy_after_accept", modwait, 1);
        model_accept(s);
        wait_result(1, use_tab, e_mag, e_sgn, e_err_m, e_err_s);
    endtask

    function automatic void add(int op, logic [15:0] val, logic [15:0] em, logic [15:0] es,
                                bit eem, bit ees);
        vec_t v;
        v.op = op; v.val = val; v.e_mag = em; v.e_sgn = es; v.e_err_m = eem; v.e_err_s = ees;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_cnt;

        // Reset mid-MAC with err already raised by an overrun.
        do_reset();
        check("reset_fir_out", fir_out, 0);
        check("reset_modwait", modwait, 0);
        check("reset_coeff_ready", coeff_ready, 0);
        for (int i = 0; i < TAPS; i++) do_load(16'h4000);
        do_sample(16'd1000, 0, '0, '0, 0, 0);
        @(negedge clk);
        data_ready = 1'b1; sample_data = 16'd1234;
        @(negedge clk);
        data_ready = 1'b0;
        @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        check("overrun_before_reset", err, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midrst_fir_out", fir_out, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_modwait", modwait, 0);
        check("midrst_coeff_ready", coeff_ready, 0);
        check("midrst_block_done", block_done, 0);
        check("midrst_err", err, 0);
        check("midrst_err_sgn", err_s, 0);
        ov_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid || out_valid_s) ov_cnt++;
            if (modwait) ov_cnt++;
        end
        check("midrst_no_output", ov_cnt, 0);

        // Directed vector table.
        add(OP_RST, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(OP_LOAD, 16'h4000, 0, 0, 0, 0);
        add(OP_SAMP, 16'd100, 16'd50,  16'd50,  0, 0);
        add(OP_SAMP, 16'd100, 16'd100, 16'd100, 0, 0);
        add(OP_SAMP, 16'd100, 16'd150, 16'd150, 0, 0);
        add(OP_SAMP, 16'd100, 16'd200, 16'd200, 0, 0);
        add(OP_RST, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(OP_LOAD, 16'h7FFF, 0, 0, 0, 0);
        add(OP_SAMP, 16'h7FFF, 16'h7FFE, 16'h7FFE, 0, 0);
        add(OP_SAMP, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 1);
        for (int i = 0; i < 4; i++) add(OP_LOAD, 16'h0000, 0, 0, 0, 0);
        add(OP_SAMP, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        add(OP_RST, 0, 0, 0, 0, 0);
        add(OP_LOAD, 16'h4000, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(OP_LOAD, 16'h0000, 0, 0, 0, 0);
        add(OP_SAMP, 16'hFF38, 16'h0064, 16'hFF9C, 0, 0);
        add(OP_RST, 0, 0, 0, 0, 0);
        add(OP_LOAD, 16'h8000, 0, 0, 0, 0);
        add(OP_LOAD, 16'h8000, 0, 0, 0, 0);
        add(OP_LOAD, 16'h0000, 0, 0, 0, 0);
        add(OP_LOAD, 16'h0000, 0, 0, 0, 0);
        add(OP_SAMP, 16'h4000, 16'h4000, 16'hC000, 0, 0);
        add(OP_SAMP, 16'h4000, 16'h7FFF, 16'h8000, 1, 0);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_RST:  do_reset();
                OP_LOAD: do_load(vecs[i].val);
                default: do_sample(vecs[i].val, 1, vecs[i].e_mag, vecs[i].e_sgn,
                                   vecs[i].e_err_m, vecs[i].e_err_s);
            endcase
        end

        // Overrun: second request two cycles after the first is refused.
        do_reset();
        for (int i = 0; i < TAPS; i++) do_load(16'h4000);
        @(negedge clk);
        data_ready = 1'b1; sample_data = 16'd300;
        @(negedge clk);
        data_ready = 1'b0;
        model_accept(16'd300);
        check("ovr_err_c1", err, 0);
        @(negedge clk);
        data_ready = 1'b1; sample_data = 16'd5000;
        check("ovr_err_c2", err, 0);
        @(negedge clk);
        data_ready = 1'b0;
        check("ovr_err_c3", err, 1);
        check("ovr_err_c3_sgn", err_s, 1);
        err_mag_m = 1; err_sgn_m = 1;
        wait_result(3, 0, '0, '0, 0, 0);
        do_sample(16'd0, 0, '0, '0, 0, 0);
        // Simultaneous load and sample: coefficient written, sample dropped.
        @(negedge clk);
        load_coeff = 1'b1; data_ready = 1'b1;
        fir_coefficient = 16'h2000; sample_data = 16'd9999;
        @(negedge clk);
        load_coeff = 1'b0; data_ready = 1'b0;
        model_load(16'h2000);
        check("both_err", err, 1);
        check("both_err_sgn", err_s, 1);
        @(negedge clk);
        do_sample(16'd1000, 0, '0, '0, 0, 0);

        // Block counter: 8 results give exactly two block_done pulses.
        do_reset();
        for (int i = 0; i < TAPS; i++) do_load(16'h1000);
        bd_cnt = 0;
        for (int i = 0; i < 8; i++) do_sample(16'($urandom_range(0, 2000)), 0, '0, '0, 0, 0);
        check("block_pulses", bd_cnt, 2);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < TAPS; i++) do_load(16'($urandom_range(0, 65535)));
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_sample(16'($urandom_range(0, 65535)), 0, '0, '0, 0, 0);
            else
                do_sample(16'(32'($urandom_range(0, 4000)) - 32'd2000), 0, '0, '0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
